// File: rtl/i2c_target_bridge.sv
// rtl/i2c_target_bridge.sv - I2C target register bridge; optional input filter via I2C_TARGET_GLITCH_FILTER_EN
`timescale 1ns/1ps
module i2c_target_bridge #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         SDA_HOLD    = 4
) (
    input  logic       s00_axi_aclk,
    input  logic       rstt,
    input  logic       i2c_scl_i,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       i2c_sda_t,
    output logic       reg_wr_valid,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd_req,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic [7:0] nack_cnt
);
    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_ADDR      = 4'd1;
    localparam logic [3:0] S_ADDR_ACK  = 4'd2;
    localparam logic [3:0] S_PTR       = 4'd3;
    localparam logic [3:0] S_PTR_ACK   = 4'd4;
    localparam logic [3:0] S_WDATA     = 4'd5;
    localparam logic [3:0] S_WDATA_ACK = 4'd6;
    localparam logic [3:0] S_RDATA     = 4'd7;
    localparam logic [3:0] S_RDATA_ACK = 4'd8;
    localparam logic [3:0] S_IGNORE    = 4'd9;
    localparam logic [3:0] HOLD_CYC    = 4'(SDA_HOLD);

    logic       scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic       sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    logic       scl_p_q, scl_p_d, sda_p_q, sda_p_d;
    logic       scl_lvl, sda_lvl;
    logic [3:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic [7:0] nack_cnt_q, nack_cnt_d;
    logic       wr_valid_q, wr_valid_d;
    logic       rd_req_q, rd_req_d;
    logic       rd_load_q, rd_load_d;
    logic       sda_t_q, sda_t_d;
    logic       sda_next_q, sda_next_d;
    logic       hold_pend_q, hold_pend_d;
    logic [3:0] hold_cnt_q, hold_cnt_d;
    logic       scl_rise, scl_fall, start_c, stop_c;
    logic [7:0] byte_in;

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic       scl_f_q, scl_f_d, sda_f_q, sda_f_d;
    logic [1:0] scl_fc_q, scl_fc_d, sda_fc_q, sda_fc_d;

    // Filtered level follows the synchronizer only after 3 consecutive differing samples
    always_comb begin
        scl_f_d  = scl_f_q;
        scl_fc_d = scl_fc_q;
        sda_f_d  = sda_f_q;
        sda_fc_d = sda_fc_q;
        if (scl_s2_q == scl_f_q) begin
            scl_fc_d = 2'd0;
        end else if (scl_fc_q == 2'd2) begin
            scl_f_d  = scl_s2_q;
            scl_fc_d = 2'd0;
        end else begin
            scl_fc_d = scl_fc_q + 2'd1;
        end
        if (sda_s2_q == sda_f_q) begin
            sda_fc_d = 2'd0;
        end else if (sda_fc_q == 2'd2) begin
            sda_f_d  = sda_s2_q;
            sda_fc_d = 2'd0;
        end else begin
            sda_fc_d = sda_fc_q + 2'd1;
        end
    end

    // Filter state registers; idle bus reads as high
    always_ff @(posedge s00_axi_aclk) begin
        if (rstt) begin
            scl_f_q  <= 1'b1;
            sda_f_q  <= 1'b1;
            scl_fc_q <= 2'd0;
            sda_fc_q <= 2'd0;
        end else begin
            scl_f_q  <= scl_f_d;
            sda_f_q  <= sda_f_d;
            scl_fc_q <= scl_fc_d;
            sda_fc_q <= sda_fc_d;
        end
    end

    assign scl_lvl = scl_f_q;
    assign sda_lvl = sda_f_q;
`else
    assign scl_lvl = scl_s2_q;
    assign sda_lvl = sda_s2_q;
`endif

    assign scl_rise = scl_lvl & ~scl_p_q;
    assign scl_fall = ~scl_lvl & scl_p_q;
    assign start_c  = scl_lvl & scl_p_q & ~sda_lvl & sda_p_q;
    assign stop_c   = scl_lvl & scl_p_q & sda_lvl & ~sda_p_q;
    assign byte_in  = {shift_q[6:0], sda_lvl};

    // Bus decode, protocol FSM, delayed SDA drive and register-port pulses
    always_comb begin
        scl_s1_d    = i2c_scl_i;
        scl_s2_d    = scl_s1_q;
        sda_s1_d    = i2c_sda_i;
        sda_s2_d    = sda_s1_q;
        scl_p_d     = scl_lvl;
        sda_p_d     = sda_lvl;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        busy_d      = busy_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        nack_cnt_d  = nack_cnt_q;
        wr_valid_d  = 1'b0;
        rd_req_d    = 1'b0;
        rd_load_d   = rd_req_q;
        sda_t_d     = sda_t_q;
        sda_next_d  = sda_next_q;
        hold_pend_d = hold_pend_q;
        hold_cnt_d  = hold_cnt_q;

        // write pointer advances the cycle after the write strobe
        if (wr_valid_q) reg_addr_d = reg_addr_q + 8'd1;
        if (rd_load_q)  shift_d    = reg_rdata;

        // apply the scheduled SDA level once the hold delay expires; never while SCL is high
        if (hold_pend_q) begin
            if (scl_lvl) begin
                hold_pend_d = 1'b0;
            end else if (hold_cnt_q <= 4'd1) begin
                sda_t_d     = sda_next_q;
                hold_pend_d = 1'b0;
            end else begin
                hold_cnt_d = hold_cnt_q - 4'd1;
            end
        end

        if (stop_c) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            sda_t_d     = 1'b1;
            hold_pend_d = 1'b0;
        end else if (start_c) begin
            state_d     = S_ADDR;
            bit_cnt_d   = 3'd0;
            busy_d      = 1'b1;
            sda_t_d     = 1'b1;
            hold_pend_d = 1'b0;
        end else begin
            if (scl_fall) begin
                hold_pend_d = 1'b1;
                hold_cnt_d  = HOLD_CYC;
                case (state_q)
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: sda_next_d = 1'b0;
                    S_RDATA:                            sda_next_d = shift_q[7];
                    default:                            sda_next_d = 1'b1;
                endcase
                if (state_q == S_ADDR_ACK && rw_q) rd_req_d = 1'b1;
            end
            if (scl_rise) begin
                case (state_q)
                    S_ADDR: begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_in[7:1] == TARGET_ADDR) begin
                                state_d = S_ADDR_ACK;
                                rw_d    = byte_in[0];
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        state_d   = rw_q ? S_RDATA : S_PTR;
                        bit_cnt_d = 3'd0;
                    end
                    S_PTR: begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_addr_d = byte_in;
                            state_d    = S_PTR_ACK;
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        state_d   = S_WDATA;
                        bit_cnt_d = 3'd0;
                    end
                    S_WDATA: begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            reg_wdata_d = byte_in;
                            wr_valid_d  = 1'b1;
                            state_d     = S_WDATA_ACK;
                        end
                    end
                    S_RDATA: begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = S_RDATA_ACK;
                    end
                    S_RDATA_ACK: begin
                        bit_cnt_d = 3'd0;
                        if (!sda_lvl) begin
                            reg_addr_d = reg_addr_q + 8'd1;
                            rd_req_d   = 1'b1;
                            state_d    = S_RDATA;
                        end else begin
                            if (nack_cnt_q != 8'hFF) nack_cnt_d = nack_cnt_q + 8'd1;
                            state_d = S_IGNORE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers with synchronous reset to an idle, released bus
    always_ff @(posedge s00_axi_aclk) begin
        if (rstt) begin
            scl_s1_q    <= 1'b1;
            scl_s2_q    <= 1'b1;
            sda_s1_q    <= 1'b1;
            sda_s2_q    <= 1'b1;
            scl_p_q     <= 1'b1;
            sda_p_q     <= 1'b1;
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
            reg_addr_q  <= 8'd0;
            reg_wdata_q <= 8'd0;
            nack_cnt_q  <= 8'd0;
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_load_q   <= 1'b0;
            sda_t_q     <= 1'b1;
            sda_next_q  <= 1'b1;
            hold_pend_q <= 1'b0;
            hold_cnt_q  <= 4'd0;
        end else begin
            scl_s1_q    <= scl_s1_d;
            scl_s2_q    <= scl_s2_d;
            sda_s1_q    <= sda_s1_d;
            sda_s2_q    <= sda_s2_d;
            scl_p_q     <= scl_p_d;
            sda_p_q     <= sda_p_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            nack_cnt_q  <= nack_cnt_d;
            wr_valid_q  <= wr_valid_d;
            rd_req_q    <= rd_req_d;
            rd_load_q   <= rd_load_d;
            sda_t_q     <= sda_t_d;
            sda_next_q  <= sda_next_d;
            hold_pend_q <= hold_pend_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign i2c_sda_o    = 1'b0;
    assign i2c_sda_t    = sda_t_q;
    assign reg_wr_valid = wr_valid_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wdata    = reg_wdata_q;
    assign reg_rd_req   = rd_req_q;
    assign busy         = busy_q;
    assign nack_cnt     = nack_cnt_q;
endmodule

// File: doc/i2c_target_bridge.md
Name: i2c_target_bridge

Overview:
- I2C target (slave) responder, the far end of the bus driven by the team's AXI-controlled I2C master.
- Decodes the 7-bit address and an 8-bit register pointer, and accepts write bytes.
- Serves read bytes with pointer auto-increment.
- Exposes a simple byte-wide local register port to fabric logic.
- Used as a loopback target for master bring-up and as a PL-side I2C register slave.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target ACKs.
- SDA_HOLD, 4, clock cycles between detected SCL fall and SDA update (range 1-15).

Ports:
- s00_axi_aclk  input  1  system clock; all logic on rising edge.
- rstt  input  1  synchronous active-high reset.
- i2c_scl_i  input  1  SCL pad input (asynchronous).
- i2c_sda_i  input  1  SDA pad input (asynchronous).
- i2c_sda_o  output  1  SDA output value; constant 0.
- i2c_sda_t  output  1  SDA tristate; 1 = released, 0 = pull low.
- reg_wr_valid  output  1  one-cycle pulse; reg_addr/reg_wdata valid.
- reg_addr  output  8  current register pointer.
- reg_wdata  output  8  byte received from master.
- reg_rd_req  output  1  one-cycle pulse; fabric presents reg_rdata next cycle.
- reg_rdata  input  8  read byte for reg_addr, sampled 1 cycle after reg_rd_req.
- busy  output  1  high from START until STOP.
- nack_cnt  output  8  count of master NACKs on read bytes; saturates at 255.

Behaviour:
- Reset values:
  - i2c_sda_t=1, reg_wr_valid=0, reg_rd_req=0, busy=0, nack_cnt=0, reg_addr=0, reg_wdata=0.
  - FSM in IDLE.
- Input sync: 2-FF synchronizer on SCL/SDA, then a registered copy for edge detect. Event latency is 3 cycles from the pin.
- Bus conditions:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Both are detected in every state, including mid-byte, and take priority over bit sampling.
- Bit sampling: data bits are shifted MSB first on the synchronized SCL rising edge.
- Drive timing:
  - SDA is changed only SDA_HOLD cycles after a synchronized SCL falling edge.
  - SDA is never changed while SCL is high.
  - No clock stretching.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- IDLE: START goes to ADDR with bit counter 0 and busy set.
- ADDR: after 8 bits, compare [7:1] with TARGET_ADDR.
  - Match: go to ADDR_ACK with the R/W bit latched.
  - Mismatch: go to IGNORE; SDA stays released.
- ADDR_ACK: pull SDA low for the 9th clock, release after its falling edge + SDA_HOLD.
  - W=0 goes to PTR.
  - R=1 pulses reg_rd_req during the ACK low phase, then goes to RDATA.
- PTR: 8 bits load reg_addr, go to PTR_ACK (always ACK), then WDATA.
- WDATA: 8 bits go to WDATA_ACK.
  - reg_wdata updated and reg_wr_valid pulsed 1 cycle at the 8th SCL rise.
  - reg_addr increments mod 256 one cycle after the pulse.
  - ACK always.
- RDATA:
  - Shift register loaded from reg_rdata one cycle after reg_rd_req.
  - MSB driven on the first SCL fall + SDA_HOLD. A 1 bit releases SDA; a 0 bit pulls it low.
  - After 8 bits, release SDA and go to RDATA_ACK.
- RDATA_ACK: sample master bit on the 9th SCL rise.
  - ACK (0): increment reg_addr, pulse reg_rd_req, return to RDATA.
  - NACK (1): nack_cnt+1 (saturating), go to IGNORE.
- Repeated START in any non-IDLE state: go to ADDR; reg_addr is kept, enabling the write-pointer-then-read sequence.
- STOP in any state: go to IDLE, busy=0, SDA released within 1 cycle of detection.
- IGNORE: SDA released; wait for START or STOP only.
- Reset mid-transfer: immediate IDLE, SDA released, no pulses. The pulse lost on the same cycle as reset is dropped.
- reg_addr wraps 8'hFF to 8'h00 on both the write and read paths.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined:
  - A 3-cycle stability filter follows the synchronizers.
  - A filtered SCL/SDA level changes only after 3 consecutive equal samples.
  - Pulses of 2 cycles or fewer are rejected.
  - Event latency becomes 6 cycles from the pin.
- Undefined: no filter; latency 3 cycles.

Test Plan:
- Write: START, 0xA0, ptr 0x10, data 0x5A, 0xC3, STOP:
  - 3 ACKs after the address byte, 4 ACKs total.
  - reg_wr_valid pulses with (0x10,0x5A) then (0x11,0xC3).
  - busy falls after STOP.
- Combined read: START, 0xA0, ptr 0xFE, rSTART, 0xA1, read 3 bytes with ACK, ACK, NACK; fabric returns reg_rdata = reg_addr ^ 0xFF:
  - Master receives 0x01, 0x00, 0xFF (addr wrap FE→FF→00).
  - nack_cnt = 1.
- Address mismatch: START, 0xA2 + 2 bytes, STOP:
  - i2c_sda_t stays 1 for the whole transfer; no reg_wr_valid.
  - FSM back in IDLE.
- STOP after bit 4 of a data byte:
  - No reg_wr_valid; IDLE; next transfer is ACKed normally.
- rstt asserted during RDATA with SDA driven low:
  - i2c_sda_t=1 the next cycle; all outputs at reset values.
- With I2C_TARGET_GLITCH_FILTER_EN:
  - A 2-cycle SDA low pulse while SCL is high causes no START.
  - A 4-cycle pulse causes START (busy=1).
